// File: rtl/r5fp_sqrt_issue_pkg.sv
// r5fp_sqrt_issue_pkg: shared types and constants for the sqrt issue controller
package r5fp_sqrt_issue_pkg;
  localparam int R5_SIG_W = 23;
  localparam int R5_EXP_W = 8;
  localparam int R5_TAG_W = 4;
  localparam int ST_NV = 4;
  localparam int ST_DZ = 3;
  localparam int ST_OF = 2;
  localparam int ST_UF = 1;
  localparam int ST_NX = 0;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;
  typedef struct packed {
    logic [R5_SIG_W+R5_EXP_W:0] a;
    logic [2:0]                 rnd;
    logic [R5_TAG_W-1:0]        tag;
  } req_t;
endpackage

// File: rtl/r5fp_sync_fifo.sv
// r5fp_sync_fifo: power-of-two synchronous FIFO with wrapping pointers and clear
module r5fp_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  assign dout  = mem[rp];
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  // storage write, no reset needed since count gates visibility
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  // pointers and occupancy; clear drops every entry
  always_ff @(posedge clk)
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= push ? wp + 1'b1 : wp;
      rp  <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/r5fp_sqrt_issue_ctrl.sv
// r5fp_sqrt_issue_ctrl: queues sqrt requests, launches one at a time, returns results (flush via R5FP_SQRT_FLUSH_EN)
module r5fp_sqrt_issue_ctrl
  import r5fp_sqrt_issue_pkg::*;
#(
  parameter int SIG_W = R5_SIG_W,
  parameter int EXP_W = R5_EXP_W,
  parameter int TAG_W = R5_TAG_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [SIG_W+EXP_W:0]   req_a_i,
  input  logic [2:0]             req_rnd_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  output logic [SIG_W+EXP_W:0]   core_a_o,
  output logic [2:0]             core_rnd_o,
  output logic                   core_strobe_o,
  input  logic                   core_ready_i,
  input  logic                   core_done_i,
  input  logic [SIG_W+EXP_W:0]   core_z_i,
  input  logic [7:0]             core_status_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [SIG_W+EXP_W:0]   rsp_z_o,
  output logic [7:0]             rsp_status_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  input  logic                   flush_i
);
  state_t           state, next;
  req_t             push_req, head;
  logic             full, empty, push, launch, flush;
  logic [TAG_W-1:0] tag;
`ifdef R5FP_SQRT_FLUSH_EN
  assign flush = flush_i;
`else
  logic unused_flush;
  assign flush        = 1'b0;
  assign unused_flush = flush_i;
`endif
  assign push_req      = '{a: req_a_i, rnd: req_rnd_i, tag: req_tag_i};
  assign req_ready_o   = !full && !reset;
  assign push          = req_valid_i && req_ready_o && !flush;
  assign launch        = !reset && !flush && !empty && core_ready_i &&
                         (state == IDLE || (state == RESP && rsp_ready_i));
  assign core_strobe_o = launch;
  assign rsp_valid_o   = state == RESP;
  r5fp_sync_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .push (push),
    .pop  (launch),
    .din  (push_req),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  // next state: launch, wait for done, hold response, or drain a flushed op
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = launch ? BUSY : IDLE;
      BUSY:    next = flush ? (core_done_i ? IDLE : DRAIN) : (core_done_i ? RESP : BUSY);
      RESP:    next = launch ? BUSY : (flush || rsp_ready_i) ? IDLE : RESP;
      default: next = core_done_i ? IDLE : DRAIN;
    endcase
  end
  // operand and tag held for the core from launch until the next launch
  always_ff @(posedge clk)
    if (reset) begin
      core_a_o   <= '0;
      core_rnd_o <= '0;
      tag        <= '0;
    end else if (launch) begin
      core_a_o   <= head.a;
      core_rnd_o <= head.rnd;
      tag        <= head.tag;
    end
  // response capture on the core's done pulse, frozen until the next result
  always_ff @(posedge clk)
    if (reset) begin
      rsp_z_o      <= '0;
      rsp_status_o <= '0;
      rsp_tag_o    <= '0;
    end else if (state == BUSY && core_done_i && !flush) begin
      rsp_z_o      <= core_z_i;
      rsp_status_o <= core_status_i;
      rsp_tag_o    <= tag;
    end
endmodule

// File: tb/tb_r5fp_sqrt_issue_ctrl.sv
// tb_r5fp_sqrt_issue_ctrl: directed and random checks against a queue-based model
module tb_r5fp_sqrt_issue_ctrl;
  localparam int DEPTH = 2;
  typedef struct packed {logic [31:0] a; logic [2:0] rnd; logic [3:0] tag;} rq_t;
  typedef enum {M_IDLE, M_BUSY, M_RESP, M_DRAIN} ms_t;
  logic clk = 0, reset = 1;
  logic req_valid_i = 0, req_ready_o;
  logic [31:0] req_a_i = 0;
  logic [2:0] req_rnd_i = 0;
  logic [3:0] req_tag_i = 0;
  logic [31:0] core_a_o;
  logic [2:0] core_rnd_o;
  logic core_strobe_o, core_ready_i = 0, core_done_i = 0;
  logic [31:0] core_z_i = 0;
  logic [7:0] core_status_i = 0;
  logic rsp_valid_o, rsp_ready_i = 0;
  logic [31:0] rsp_z_o;
  logic [7:0] rsp_status_o;
  logic [3:0] rsp_tag_o;
  logic flush_i = 0;
  int total = 0, bad = 0;
  rq_t q[$], dir_q[$];
  rq_t launched;
  ms_t ms = M_IDLE;
  logic [31:0] exp_z;
  logic [7:0] exp_st;
  logic [3:0] exp_tag;
  bit core_busy = 0, rand_en = 0, rsp_hold = 0, rst_want = 1, flush_want = 0;
  int cdelay = 0, dly_fix = 2;

  always #5 clk = ~clk;

  r5fp_sqrt_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
    .core_a_o(core_a_o), .core_rnd_o(core_rnd_o), .core_strobe_o(core_strobe_o),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_z_i(core_z_i),
    .core_status_i(core_status_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_z_o(rsp_z_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o), .flush_i(flush_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // stand-in sqrt core: returns {status, z}
  function automatic logic [39:0] core_fn(input logic [31:0] a);
    if (a == 32'h4080_0000) return {8'h00, 32'h4000_0000};
    if (a[31] && a[30:0] != 0) return {8'h10, 32'h7FC0_0000};
    return {3'b0, a[4:0], a ^ 32'h5A5A_0F0F};
  endfunction

  task automatic observe();
    bit fl, er, el, pushed;
    fl = flush_i && !reset;
    er = !reset && q.size() < DEPTH;
    el = !reset && !fl && q.size() > 0 && core_ready_i &&
         (ms == M_IDLE || (ms == M_RESP && rsp_ready_i));
    chk("req_ready", req_ready_o, er);
    chk("strobe", core_strobe_o, el);
    chk("rsp_valid", rsp_valid_o, ms == M_RESP);
    if (ms == M_RESP) begin
      chk("rsp_z", rsp_z_o, exp_z);
      chk("rsp_status", rsp_status_o, exp_st);
      chk("rsp_tag", rsp_tag_o, exp_tag);
    end
    if (ms == M_BUSY) begin
      chk("core_a", core_a_o, launched.a);
      chk("core_rnd", core_rnd_o, launched.rnd);
    end
    if (core_strobe_o) begin
      core_busy = 1;
      cdelay = dly_fix >= 0 ? dly_fix : $urandom_range(0, 4);
    end
    pushed = req_valid_i && req_ready_o;
    if (pushed && dir_q.size() > 0) void'(dir_q.pop_front());
    if (reset) begin
      q.delete();
      ms = M_IDLE;
    end else if (fl) begin
      q.delete();
      ms = ((ms == M_BUSY || ms == M_DRAIN) && !core_done_i) ? M_DRAIN : M_IDLE;
    end else begin
      if (el) launched = q.pop_front();
      if (pushed) q.push_back('{req_a_i, req_rnd_i, req_tag_i});
      case (ms)
        M_IDLE: if (el) ms = M_BUSY;
        M_BUSY: if (core_done_i) begin
          {exp_st, exp_z} = core_fn(launched.a);
          exp_tag = launched.tag;
          ms = M_RESP;
        end
        M_RESP: if (rsp_ready_i) ms = el ? M_BUSY : M_IDLE;
        default: if (core_done_i) ms = M_IDLE;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset = rst_want;
    flush_i = flush_want;
    core_done_i = 0;
    core_z_i = 0;
    core_status_i = 0;
    if (core_busy) begin
      if (cdelay == 0) begin
        {core_status_i, core_z_i} = core_fn(core_a_o);
        core_done_i = 1;
        core_busy = 0;
      end else cdelay--;
    end
    core_ready_i = !core_busy && (!rand_en || $urandom_range(0, 3) != 0);
    if (dir_q.size() > 0) begin
      req_valid_i = 1;
      {req_a_i, req_rnd_i, req_tag_i} = dir_q[0];
    end else if (rand_en && $urandom_range(0, 2) == 0) begin
      req_valid_i = 1;
      req_a_i = $urandom;
      req_rnd_i = 3'($urandom_range(0, 7));
      req_tag_i = 4'($urandom_range(0, 15));
    end else req_valid_i = 0;
    rsp_ready_i = !rsp_hold && (!rand_en || $urandom_range(0, 1) == 1);
    @(negedge clk);
    observe();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (ms == M_IDLE && q.size() == 0 && dir_q.size() == 0 && !core_busy) return;
      step();
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_state(input ms_t s);
    for (int i = 0; i < 100; i++) begin
      if (ms == s) return;
      step();
    end
    chk("state_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ready", req_ready_o, 0);
    chk("rst_strobe", core_strobe_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_core_a", core_a_o, 0);
    chk("rst_core_rnd", core_rnd_o, 0);
    chk("rst_rsp_z", rsp_z_o, 0);
    chk("rst_rsp_status", rsp_status_o, 0);
    chk("rst_rsp_tag", rsp_tag_o, 0);
    rst_want = 0;
    step();
    dir_q.push_back('{32'h4080_0000, 3'd0, 4'd3});
    wait_idle();
    dir_q.push_back('{32'hBF80_0000, 3'd1, 4'd7});
    wait_idle();
    dly_fix = 3;
    dir_q.push_back('{32'h4100_0000, 3'd2, 4'd1});
    dir_q.push_back('{32'h4200_0000, 3'd3, 4'd2});
    dir_q.push_back('{32'h4300_0000, 3'd4, 4'd4});
    wait_idle();
    dir_q.push_back('{32'h3F80_0000, 3'd0, 4'd9});
    dir_q.push_back('{32'h4040_0000, 3'd1, 4'd10});
    rsp_hold = 1;
    wait_state(M_RESP);
    repeat (10) step();
    rsp_hold = 0;
    wait_idle();
    dly_fix = 6;
    dir_q.push_back('{32'h4500_0000, 3'd0, 4'd5});
    dir_q.push_back('{32'h4600_0000, 3'd0, 4'd6});
    wait_state(M_BUSY);
    rst_want = 1;
    dir_q.delete();
    repeat (2) step();
    rst_want = 0;
    wait_idle();
    repeat (5) step();
`ifdef R5FP_SQRT_FLUSH_EN
    dir_q.push_back('{32'h4700_0000, 3'd0, 4'd11});
    dir_q.push_back('{32'h4800_0000, 3'd0, 4'd12});
    wait_state(M_BUSY);
    chk("flush_queued", q.size(), 1);
    flush_want = 1;
    step();
    flush_want = 0;
    wait_idle();
    repeat (5) step();
`endif
    rand_en = 1;
    dly_fix = -1;
    repeat (3000) step();
    rand_en = 0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
